// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte requesters.
// A watchdog aborts a transfer whose uart_tx done edge never arrives.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_data,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_done,
  output logic                   o_timeout,
  output logic                   o_busy,
  output logic                   o_tx_start,
  output logic [7:0]             o_tx_data,
  input  logic                   i_tx_done,
  input  logic                   i_tx_busy
);

  // state   | meaning
  // S_IDLE  | no transfer; arbitrate once uart_tx is free
  // S_START | one-cycle o_tx_start and o_grant to the owner
  // S_WAIT  | byte on the wire; wait for a done rise or the watchdog
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int unsigned        IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [15:0]        WD_LAST  = TIMEOUT_CYCLES - 16'd1;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   last_owner, last_owner_next;
  logic [15:0]        wd, wd_next;
  logic               tx_done_q;
  logic               rise;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   winner;
  logic               found;

  logic [NUM_REQ-1:0] grant_next;
  logic [NUM_REQ-1:0] done_next;
  logic               timeout_next;
  logic               busy_next;
  logic               start_next;
  logic [7:0]         tx_data_next;

  assign rise = i_tx_done & ~tx_done_q;

  // Walk upward from the slot after the last owner, wrapping at NUM_REQ-1.
  always_comb begin
    cand   = last_owner;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && i_req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    wd_next         = wd;
    tx_data_next    = o_tx_data;
    grant_next      = '0;
    done_next       = '0;
    timeout_next    = 1'b0;
    start_next      = 1'b0;

    case (state)
      S_IDLE: begin
        if (found && !i_tx_busy) begin
          state_next         = S_START;
          owner_next         = winner;
          tx_data_next       = i_data[{winner, 3'b000} +: 8];
          start_next         = 1'b1;
          grant_next[winner] = 1'b1;
        end
      end
      S_START: begin
        state_next = S_WAIT;
        wd_next    = '0;
      end
      S_WAIT: begin
        // A done rise takes priority over a watchdog expiring on the same edge.
        if (rise) begin
          done_next[owner] = 1'b1;
          last_owner_next  = owner;
          state_next       = S_IDLE;
        end else if (wd == WD_LAST) begin
          timeout_next    = 1'b1;
          last_owner_next = owner;
          state_next      = S_IDLE;
        end else begin
          wd_next = wd + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= LAST_IDX;
      wd         <= '0;
      tx_done_q  <= 1'b0;
      o_grant    <= '0;
      o_done     <= '0;
      o_timeout  <= 1'b0;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      wd         <= wd_next;
      tx_done_q  <= i_tx_done;
      o_grant    <= grant_next;
      o_done     <= done_next;
      o_timeout  <= timeout_next;
      o_busy     <= busy_next;
      o_tx_start <= start_next;
      o_tx_data  <= tx_data_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single transfers plus
// hand sequences for busy gating, timeout, reset abort and fairness.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_grant;
  logic [3:0]  o_done;
  logic        o_timeout;
  logic        o_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        i_tx_busy;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16'd64)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_grant    (o_grant),
    .o_done     (o_done),
    .o_timeout  (o_timeout),
    .o_busy     (o_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .i_tx_busy  (i_tx_busy)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  txd;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_req     = '0;
    i_data    = '0;
    i_tx_done = 1'b0;
    i_tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int n);
    g = '0;
    n = 0;
    while (g == 4'b0 && n < 40) begin
      @(negedge clk);
      n++;
      g = o_grant;
    end
  endtask

  // Called at the negedge where the grant was seen; plays uart_tx and checks the done pulse.
  task automatic finish(input logic [3:0] g, input logic [7:0] txd);
    int pulses;
    int tos;
    logic [3:0] dv;
    i_req     = '0;
    i_data    = 32'hDEADBEEF;
    i_tx_busy = 1'b1;
    @(negedge clk);
    check("start_one_cycle", 32'({o_grant, o_tx_start}), 32'd0);
    @(negedge clk);
    check("data_hold", 32'(o_tx_data), 32'(txd));
    i_tx_done = 1'b1;
    pulses = 0;
    tos    = 0;
    dv     = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (o_done != 4'b0) begin
        pulses++;
        dv = o_done;
      end
      if (o_timeout) tos++;
      if (j == 1) begin
        i_tx_done = 1'b0;
        i_tx_busy = 1'b0;
      end
    end
    check("done_count", pulses, 32'd1);
    check("done_owner", 32'(dv), 32'(g));
    check("no_timeout", tos, 32'd0);
    check("idle_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [3:0] g;
    int n;
    int cnt;

    vecs[0] = '{4'b0100, 32'h00AB0000, 4'b0100, 8'hAB};
    vecs[1] = '{4'b1111, 32'h44332211, 4'b1000, 8'h44};
    vecs[2] = '{4'b1111, 32'h44332211, 4'b0001, 8'h11};
    vecs[3] = '{4'b0110, 32'h55667788, 4'b0010, 8'h77};
    vecs[4] = '{4'b1001, 32'h99000066, 4'b1000, 8'h99};
    vecs[5] = '{4'b0001, 32'h000000C3, 4'b0001, 8'hC3};
    vecs[6] = '{4'b0001, 32'h000000D4, 4'b0001, 8'hD4};
    vecs[7] = '{4'b1010, 32'hF000E500, 4'b0010, 8'hE5};

    i_rst     = 1'b1;
    i_req     = '0;
    i_data    = '0;
    i_tx_done = 1'b0;
    i_tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({o_grant, o_done, o_timeout, o_busy, o_tx_start, o_tx_data}), 32'd0);
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 32'({o_grant, o_done, o_timeout, o_busy, o_tx_start, o_tx_data}), 32'd0);

    for (int v = 0; v < 8; v++) begin
      i_req  = vecs[v].req;
      i_data = vecs[v].data;
      wait_grant(g, n);
      check("grant_latency", n, 32'd1);
      check("grant", 32'(g), 32'(vecs[v].grant));
      check("tx_start", 32'(o_tx_start), 32'd1);
      check("tx_data", 32'(o_tx_data), 32'(vecs[v].txd));
      check("busy_start", 32'(o_busy), 32'd1);
      finish(g, vecs[v].txd);
    end

    // busy gating
    i_tx_busy = 1'b1;
    i_req     = 4'b0001;
    i_data    = 32'h0000003C;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_grant != 4'b0) cnt++;
    end
    check("busy_blocks_grant", cnt, 32'd0);
    i_tx_busy = 1'b0;
    @(negedge clk);
    check("grant_after_busy", 32'(o_grant), 32'h1);
    finish(4'b0001, 8'h3C);

    // done level already high when WAIT begins is not a rise
    i_tx_done = 1'b1;
    @(negedge clk);
    check("rise_in_idle_ignored", 32'(o_done), 32'd0);
    i_req  = 4'b0001;
    i_data = 32'h0000004D;
    wait_grant(g, n);
    check("held_grant", 32'(g), 32'h1);
    i_req = '0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done != 4'b0) cnt++;
    end
    check("held_level_no_done", cnt, 32'd0);
    i_tx_done = 1'b0;
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    check("late_rise_done", 32'(o_done), 32'h1);
    i_tx_done = 1'b0;
    @(negedge clk);

    // watchdog expiry
    i_req  = 4'b0100;
    i_data = 32'h00770000;
    wait_grant(g, n);
    i_req     = '0;
    i_tx_busy = 1'b1;
    n   = 0;
    cnt = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (o_done != 4'b0) cnt++;
      if (o_timeout) break;
    end
    check("timeout_delay", n, 32'd65);
    check("timeout_no_done", cnt, 32'd0);
    @(negedge clk);
    check("timeout_one_cycle", 32'(o_timeout), 32'd0);
    check("timeout_idle", 32'(o_busy), 32'd0);
    i_tx_busy = 1'b0;

    // rise on the same edge the watchdog would fire
    i_req  = 4'b0010;
    i_data = 32'h00001200;
    wait_grant(g, n);
    check("tie_grant", 32'(g), 32'h2);
    i_req = '0;
    repeat (64) @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    check("tie_done_wins", 32'(o_done), 32'h2);
    check("tie_no_timeout", 32'(o_timeout), 32'd0);
    i_tx_done = 1'b0;
    @(negedge clk);
    check("tie_no_late_timeout", 32'(o_timeout), 32'd0);

    // reset while requester 2 is in flight
    do_reset();
    i_req  = 4'b0100;
    i_data = 32'h00880000;
    wait_grant(g, n);
    check("rst_pre_grant", 32'(g), 32'h4);
    i_req     = '0;
    i_tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", 32'({o_grant, o_done, o_timeout, o_busy, o_tx_start, o_tx_data}), 32'd0);
    i_rst     = 1'b0;
    i_tx_busy = 1'b0;
    i_tx_done = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_done != 4'b0 || o_timeout) cnt++;
    end
    check("rst_no_pulses", cnt, 32'd0);
    i_tx_done = 1'b0;
    i_req     = 4'b0110;
    i_data    = 32'h00005A00;
    wait_grant(g, n);
    check("rst_next_grant", 32'(g), 32'h2);
    check("rst_next_data", 32'(o_tx_data), 32'h5A);
    finish(4'b0010, 8'h5A);

    // fairness with back-to-back transfers at minimum spacing
    do_reset();
    i_req  = 4'b1001;
    i_data = 32'hB00000A0;
    for (int t = 0; t < 8; t++) begin
      wait_grant(g, n);
      check("rr_grant", 32'(g), (t % 2 == 0) ? 32'h1 : 32'h8);
      check("rr_spacing", n, 32'd1);
      @(negedge clk);
      i_tx_done = 1'b1;
      @(negedge clk);
      check("rr_done", 32'(o_done), 32'(g));
      i_tx_done = 1'b0;
      if (t == 7) i_req = '0;
    end
    @(negedge clk);
    check("rr_final_idle", 32'(o_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd8192: maximum clock cycles in WAIT before the transfer is aborted.
REQ-003 Port i_clk  input  1: single system clock; all logic on its rising edge.
REQ-004 Port i_rst  input  1: reset, synchronous and active-high.
REQ-005 Port i_req  input  NUM_REQ: per-requester request level; held high until the matching o_grant bit is seen.
REQ-006 Port i_data  input  8*NUM_REQ: packed bytes; requester k uses bits [8k+7:8k].
REQ-007 Port o_grant  output  NUM_REQ: one-hot, one-cycle pulse; the requester's byte was accepted this cycle.
REQ-008 Port o_done  output  NUM_REQ: one-hot, one-cycle pulse; the granted requester's byte finished transmitting.
REQ-009 Port o_timeout  output  1: one-cycle pulse; the transfer in flight was aborted by the watchdog.
REQ-010 Port o_busy  output  1: high in every state except IDLE.
REQ-011 Port o_tx_start  output  1: drives uart_tx i_start.
REQ-012 Port o_tx_data  output  8: drives uart_tx i_data; held stable from START until the return to IDLE.
REQ-013 Port i_tx_done  input  1: from uart_tx o_done; only the rising edge is significant.
REQ-014 Port i_tx_busy  input  1: from uart_tx o_busy.

Function
REQ-015 The FSM shall have three states, IDLE, START and WAIT, with every output registered.
REQ-016 IDLE -> START on the first edge where (i_req != 0 && !i_tx_busy); otherwise the FSM remains in IDLE.
REQ-017 Arbitration shall be round-robin, searching from index (last_owner+1) mod NUM_REQ upward with wrap-around; last_owner resets to NUM_REQ-1, so index 0 wins first.
REQ-018 On the IDLE->START edge, the winner's byte shall be latched into o_tx_data and its index into owner.
REQ-019 In START (exactly one cycle), o_tx_start=1 and o_grant[owner]=1 in the same cycle; START -> WAIT unconditionally.
REQ-020 Latency: request sampled at edge N gives o_grant and o_tx_start high during cycle N+1.
REQ-021 In WAIT, rise = i_tx_done & ~tx_done_q (tx_done_q is i_tx_done registered); rise -> o_done[owner] pulse for one cycle, last_owner<=owner, next state IDLE.
REQ-022 A watchdog counter shall clear on entry to WAIT and increment each WAIT cycle; on reaching TIMEOUT_CYCLES without a rise, o_timeout shall pulse, no o_done shall pulse, last_owner<=owner, and the next state shall be IDLE.
REQ-023 If a rise and the timeout occur in the same cycle, the rise shall win: o_done pulses, o_timeout stays low.
REQ-024 A rise on i_tx_done outside WAIT shall be ignored.
REQ-025 Changes to i_req or i_data outside the IDLE->START edge shall have no effect; a request dropped before its grant is not served.
REQ-026 A requester holding i_req after its grant is treated as a new request, served only after the round-robin pointer passes it.
REQ-027 Minimum spacing between o_tx_start pulses shall be 3 cycles (START, WAIT, IDLE); IDLE always lasts at least one cycle.

Reset
REQ-028 While i_rst=1 at an edge: state=IDLE, owner=0, last_owner=NUM_REQ-1, watchdog=0, tx_done_q=0, and o_grant, o_done, o_timeout, o_busy, o_tx_start, o_tx_data all 0.
REQ-029 Reset asserted mid-transfer shall abort silently with no o_done or o_timeout pulse; the next grant after release goes to index 0.

Verification (uart_tx instance with TICKS_PER_BIT=4, 20 ns clock, serial output looped into uart_rx)
REQ-030 Single request: i_req=4'b0100 with byte 2 = 8'hAB -> o_grant=4'b0100 one cycle after, uart_rx receives 8'hAB, o_done=4'b0100 pulses once.
REQ-031 Contention: i_req=4'b1111 held, each requester dropping its bit after its grant, bytes 8'h11/22/33/44 -> grants in order 0,1,2,3 and uart_rx receives 11,22,33,44.
REQ-032 Fairness: requesters 0 and 3 re-request continuously -> grants strictly alternate 0,3,0,3 over 8 transfers.
REQ-033 Timeout: TIMEOUT_CYCLES=64 and i_tx_done tied 0 -> o_timeout pulses 64 cycles after entry to WAIT, no o_done, and the FSM is in IDLE the next cycle.
REQ-034 Reset mid-WAIT: i_rst pulsed for 1 cycle while requester 2 is in flight -> all outputs 0, no done or timeout pulse, and the next request on 4'b0110 is granted to index 1.
REQ-035 Busy gating: i_tx_busy forced 1 with i_req=4'b0001 -> no grant until i_tx_busy falls, then grant one cycle later.
